video_pattern_gen: RTL

- Source end of the video stream consumed by the 3x3 window line buffer.
- Generates pixel timing (hsync, vsync, de) from parameterised counters, plus an 8-bit grayscale test pattern.
- Drives the Sobel pipeline input in bench and in bring-up builds, without a camera or HDMI receiver.
- Enable is honoured only on frame boundaries, so the downstream line delays never see a truncated frame.

---
 rtl/video_pattern_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_gen
// Description : Video timing generator (hsync/vsync/de) with an 8-bit
//               grayscale test pattern. Optional macro VIDEO_PATTERN_BORDER_EN
//               forces a 0xFF one-pixel border on the active area.
// Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  level,
    output logic [7:0]  pixel_out,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW       = $clog2(c_H_TOTAL);
    localparam int c_VW       = $clog2(c_V_TOTAL);
    localparam int c_HS_START = H_ACTIVE + H_FP;
    localparam int c_HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_VS_START = V_ACTIVE + V_FP;
    localparam int c_VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_HW-1:0] r_h_cnt;
    logic [c_HW-1:0] w_h_nxt;
    logic [c_VW-1:0] r_v_cnt;
    logic [c_VW-1:0] w_v_nxt;
    logic [1:0]      r_sel;
    logic [7:0]      r_level;
    logic            w_latch;

    logic [31:0] w_h;
    logic [31:0] w_v;
    logic        w_run;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_last;

    logic        w_de;
    logic        w_hs_act;
    logic        w_vs_act;
    logic        w_fs;
    logic [7:0]  w_pat;
    logic [7:0]  w_pix;

    // Widened counter views keep the decode compares and pattern bit picks
    // valid even when the counters are narrower than 8 bits.
    assign w_h          = 32'(r_h_cnt);
    assign w_v          = 32'(r_v_cnt);
    assign w_run        = (r_state == c_ST_RUN);
    assign w_h_last     = (w_h == c_H_TOTAL - 1);
    assign w_v_last     = (w_v == c_V_TOTAL - 1);
    assign w_frame_last = w_run && w_h_last && w_v_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_sel   <= '0;
            r_level <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            if (w_latch) begin
                r_sel   <= pattern_sel;
                r_level <= level;
            end
        end
    end

    // en is only consulted in IDLE and on the last pixel of a frame.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        w_latch     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (en) begin
                    w_state_nxt = c_ST_RUN;
                    w_latch     = 1'b1;
                end
            end
            c_ST_RUN: begin
                if (w_h_last) begin
                    w_h_nxt = '0;
                    if (w_v_last) begin
                        w_v_nxt = '0;
                        w_latch = en;
                        if (!en) begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_v_nxt = r_v_cnt + 1'b1;
                    end
                end else begin
                    w_h_nxt = r_h_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_de     = w_run && (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
        w_hs_act = w_run && (w_h >= c_HS_START) && (w_h < c_HS_END);
        w_vs_act = w_run && (w_v >= c_VS_START) && (w_v < c_VS_END);
        w_fs     = w_run && (w_h == 0) && (w_v == 0);
        case (r_sel)
            2'd0:    w_pat = w_h[7:0];
            2'd1:    w_pat = w_v[7:0];
            2'd2:    w_pat = (w_h[3] ^ w_v[3]) ? 8'hFF : 8'h00;
            default: w_pat = r_level;
        endcase
`ifdef VIDEO_PATTERN_BORDER_EN
        if ((w_h == 0) || (w_h == H_ACTIVE - 1) || (w_v == 0) || (w_v == V_ACTIVE - 1)) begin
            w_pat = 8'hFF;
        end
`endif
        w_pix = w_de ? w_pat : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out   <= 8'h00;
            de          <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else begin
            pixel_out   <= w_pix;
            de          <= w_de;
            frame_start <= w_fs;
            hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            if (w_frame_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
